divider_arbiter: RTL and testbench

DIVIDER_ARBITER -- requirements
Module: divider_arbiter

---
 rtl/divider_arbiter_pkg.sv | 22 ++
 rtl/divider_arbiter_rr_picker.sv | 31 +++
 rtl/divider_arbiter.sv | 159 +++++++++++++++
 tb/tb_divider_arbiter.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/divider_arbiter_pkg.sv
// Shared types and default sizing for the round-robin divider arbiter.
// Holds the controller state encoding and the pointer-width helper.
package divider_arbiter_pkg;

    localparam int DEF_WIDTH    = 17;
    localparam int DEF_OUT_SIZE = 9;
    localparam int DEF_NUM_REQ  = 4;
    localparam int DEF_TIMEOUT  = 64;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Width of a requester index; never zero so single-bit indices stay legal.
    function automatic int ptr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/divider_arbiter_rr_picker.sv
// Cyclic first-set search: finds the first requester at or after ptr,
// wrapping around, and returns it one-hot together with a found flag.
module rr_picker
    import divider_arbiter_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int PTR_W   = ptr_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_mask,
    input  logic [PTR_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic               found
);

    logic [PTR_W-1:0] idx;

    always_comb begin
        // NOTE: every output gets a default before the loop, otherwise a path that skips an assignment infers a latch.
        grant = '0;
        found = 1'b0;
        idx   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = PTR_W'((int'(ptr) + i) % NUM_REQ);
            if (!found && req_mask[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/divider_arbiter.sv
// Round-robin front end that shares one external signed divider among
// NUM_REQ requesters, with divide-by-zero bypass and a response timeout.
module divider_arbiter
    import divider_arbiter_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int OUT_SIZE = DEF_OUT_SIZE,
    parameter int NUM_REQ  = DEF_NUM_REQ,
    parameter int TIMEOUT  = DEF_TIMEOUT
) (
    input  logic                        clk_in,
    input  logic                        rst_in,
    input  logic [NUM_REQ-1:0]          req_valid_in,
    output logic [NUM_REQ-1:0]          req_ready_out,
    input  logic [NUM_REQ*WIDTH-1:0]    dividend_in,
    input  logic [NUM_REQ*WIDTH-1:0]    divisor_in,
    output logic [NUM_REQ-1:0]          result_valid_out,
    output logic signed [OUT_SIZE-1:0]  quotient_out,
    output logic                        error_out,
    output logic signed [WIDTH-1:0]     div_dividend_out,
    output logic signed [WIDTH-1:0]     div_divisor_out,
    output logic                        div_valid_out,
    input  logic signed [OUT_SIZE-1:0]  div_quotient_in,
    input  logic                        div_valid_in,
    output logic                        busy_out
);

    localparam int               PTR_W    = ptr_width(NUM_REQ);
    localparam int               CNT_W    = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(NUM_REQ - 1);

    state_t                     state, state_nxt;
    logic [PTR_W-1:0]           rr_ptr, rr_ptr_nxt;
    logic [PTR_W-1:0]           gnt_idx, gnt_idx_nxt;
    logic [CNT_W-1:0]           wait_cnt, wait_cnt_nxt;
    logic signed [WIDTH-1:0]    op_a, op_a_nxt, op_b, op_b_nxt;
    logic signed [OUT_SIZE-1:0] quot, quot_nxt;
    logic                       err, err_nxt;

    logic [NUM_REQ-1:0]         pick_grant;
    logic                       pick_found;
    logic [PTR_W-1:0]           pick_idx;
    logic signed [WIDTH-1:0]    pick_a, pick_b;

    rr_picker #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_picker (
        .req_mask (req_valid_in),
        .ptr      (rr_ptr),
        .grant    (pick_grant),
        .found    (pick_found)
    );

    // Operands of the winning requester, selected by the one-hot grant.
    always_comb begin
        pick_idx = '0;
        pick_a   = '0;
        pick_b   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (pick_grant[i]) begin
                pick_idx = PTR_W'(i);
                pick_a   = dividend_in[i*WIDTH +: WIDTH];
                pick_b   = divisor_in[i*WIDTH +: WIDTH];
            end
        end
    end

    always_ff @(posedge clk_in) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst_in) begin
            state    <= IDLE;
            rr_ptr   <= '0;
            gnt_idx  <= '0;
            wait_cnt <= '0;
            op_a     <= '0;
            op_b     <= '0;
            quot     <= '0;
            err      <= 1'b0;
        end else begin
            state    <= state_nxt;
            rr_ptr   <= rr_ptr_nxt;
            gnt_idx  <= gnt_idx_nxt;
            wait_cnt <= wait_cnt_nxt;
            op_a     <= op_a_nxt;
            op_b     <= op_b_nxt;
            quot     <= quot_nxt;
            err      <= err_nxt;
        end
    end

    always_comb begin
        state_nxt        = state;
        rr_ptr_nxt       = rr_ptr;
        gnt_idx_nxt      = gnt_idx;
        wait_cnt_nxt     = wait_cnt;
        op_a_nxt         = op_a;
        op_b_nxt         = op_b;
        quot_nxt         = quot;
        err_nxt          = err;
        req_ready_out    = '0;
        result_valid_out = '0;
        div_valid_out    = 1'b0;

        unique case (state)
            IDLE: begin
                // Reset wins over a grant, so ready never pulses while rst_in is high.
                if (pick_found && !rst_in) begin
                    req_ready_out = pick_grant;
                    gnt_idx_nxt   = pick_idx;
                    if (pick_b == '0) begin
                        quot_nxt  = '0;
                        err_nxt   = 1'b1;
                        state_nxt = DONE;
                    end else begin
                        // Operand registers double as the divider outputs and stay put until the next issue.
                        op_a_nxt  = pick_a;
                        op_b_nxt  = pick_b;
                        state_nxt = ISSUE;
                    end
                end
            end
            ISSUE: begin
                div_valid_out = 1'b1;
                wait_cnt_nxt  = '0;
                state_nxt     = WAIT;
            end
            WAIT: begin
                if (div_valid_in) begin
                    quot_nxt  = div_quotient_in;
                    err_nxt   = 1'b0;
                    state_nxt = DONE;
                end else if (wait_cnt == CNT_LAST) begin
                    quot_nxt  = '0;
                    err_nxt   = 1'b1;
                    state_nxt = DONE;
                end else begin
                    wait_cnt_nxt = wait_cnt + 1'b1;
                end
            end
            DONE: begin
                for (int i = 0; i < NUM_REQ; i++) begin
                    result_valid_out[i] = (gnt_idx == PTR_W'(i));
                end
                rr_ptr_nxt = (gnt_idx == PTR_LAST) ? '0 : gnt_idx + 1'b1;
                state_nxt  = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign quotient_out     = quot;
    assign error_out        = err;
    assign div_dividend_out = op_a;
    assign div_divisor_out  = op_b;
    assign busy_out         = (state != IDLE);

endmodule

// File: tb/tb_divider_arbiter.sv
// Directed bench for divider_arbiter with a latency-programmable divider stub;
// expected grants, latencies and quotients are hand-computed constants.
module tb_divider_arbiter;

    localparam int W  = 17;
    localparam int OS = 9;
    localparam int N  = 4;
    localparam int TO = 64;

    logic                  clk_in = 1'b0;
    logic                  rst_in;
    logic [N-1:0]          req_valid_in, req_ready_out, result_valid_out;
    logic [N*W-1:0]        dividend_in, divisor_in;
    logic signed [OS-1:0]  quotient_out, div_quotient_in;
    logic                  error_out, div_valid_out, div_valid_in, busy_out;
    logic signed [W-1:0]   div_dividend_out, div_divisor_out;

    logic                  stub_v, late_v;
    logic signed [OS-1:0]  stub_q, late_q;
    int                    stub_lat;
    int                    cyc = 0;
    int                    n_checks = 0;
    int                    n_errors = 0;

    always #5 clk_in = ~clk_in;
    always @(posedge clk_in) cyc <= cyc + 1;

    assign div_valid_in    = stub_v | late_v;
    assign div_quotient_in = late_v ? late_q : stub_q;

    divider_arbiter #(
        .WIDTH    (W),
        .OUT_SIZE (OS),
        .NUM_REQ  (N),
        .TIMEOUT  (TO)
    ) dut (
        .clk_in           (clk_in),
        .rst_in           (rst_in),
        .req_valid_in     (req_valid_in),
        .req_ready_out    (req_ready_out),
        .dividend_in      (dividend_in),
        .divisor_in       (divisor_in),
        .result_valid_out (result_valid_out),
        .quotient_out     (quotient_out),
        .error_out        (error_out),
        .div_dividend_out (div_dividend_out),
        .div_divisor_out  (div_divisor_out),
        .div_valid_out    (div_valid_out),
        .div_quotient_in  (div_quotient_in),
        .div_valid_in     (div_valid_in),
        .busy_out         (busy_out)
    );

    task automatic check(input string tag, input logic signed [31:0] got,
                         input logic signed [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Inputs change 1 ns after the edge; outputs are sampled 1 ns later.
    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic set_req(input int i, input int a, input int b);
        req_valid_in[i]           = 1'b1;
        dividend_in[i*W +: W]     = W'(a);
        divisor_in[i*W +: W]      = W'(b);
    endtask

    // Waits for the grant, then follows the operation through to its result.
    task automatic do_op(input int exp_g, input int exp_lat, input int exp_q,
                         input int exp_err, input int exp_div, input int exp_a,
                         input int exp_b);
        int           t0;
        int           waited;
        logic [N-1:0] rdy;
        #1;
        waited = 0;
        while (req_ready_out == '0 && waited < 10) begin
            step();
            #1;
            waited++;
        end
        check("grant", req_ready_out, 1 << exp_g);
        if (req_ready_out == '0) return;
        t0  = cyc;
        rdy = req_ready_out;
        step();
        req_valid_in &= ~rdy;
        #1;
        check("div_start", div_valid_out, exp_div);
        if (exp_div != 0) begin
            check("div_dividend", div_dividend_out, exp_a);
            check("div_divisor", div_divisor_out, exp_b);
        end
        waited = 0;
        while (result_valid_out == '0 && waited < 100) begin
            check("ready_while_busy", req_ready_out, 0);
            step();
            #1;
            waited++;
        end
        check("latency", cyc - t0, exp_lat);
        check("result_valid", result_valid_out, 1 << exp_g);
        check("quotient", quotient_out, exp_q);
        check("error", error_out, exp_err);
        step();
        #1;
        check("result_pulse_end", result_valid_out, 0);
    endtask

    // Divider stub: answers stub_lat cycles after each start pulse, or never when 0.
    initial begin
        int qa, qb;
        stub_v = 1'b0;
        stub_q = '0;
        forever begin
            step();
            if (div_valid_out && stub_lat > 0) begin
                qa = int'(div_dividend_out);
                qb = int'(div_divisor_out);
                repeat (stub_lat) @(posedge clk_in);
                #1;
                stub_v = 1'b1;
                stub_q = OS'(qa / qb);
                step();
                stub_v = 1'b0;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int                   q_exp [4] = '{60, 30, 20, 15};
        logic [N-1:0]         pulses;

        rst_in       = 1'b1;
        req_valid_in = '0;
        dividend_in  = '0;
        divisor_in   = '0;
        late_v       = 1'b0;
        late_q       = '0;
        stub_lat     = 3;

        // Reset with a pending request: everything stays at zero.
        set_req(0, 300, 15);
        repeat (3) step();
        #1;
        check("rst_ready", req_ready_out, 0);
        check("rst_result_valid", result_valid_out, 0);
        check("rst_quotient", quotient_out, 0);
        check("rst_error", error_out, 0);
        check("rst_div_valid", div_valid_out, 0);
        check("rst_div_dividend", div_dividend_out, 0);
        check("rst_div_divisor", div_divisor_out, 0);
        check("rst_busy", busy_out, 0);

        // Requester 0 alone: 300/15 = 20, divider latency 3.
        step();
        rst_in = 1'b0;
        do_op(0, 5, 20, 0, 1, 300, 15);

        // Requesters 1 and 3 together from rr_ptr 0.
        step();
        rst_in = 1'b1;
        step();
        rst_in = 1'b0;
        set_req(1, -300, 15);
        set_req(3, -300, -15);
        do_op(1, 5, -20, 0, 1, -300, 15);
        do_op(3, 5, 20, 0, 1, -300, -15);

        // All four held valid: eight operations in strict rotation.
        stub_lat = 1;
        for (int op = 0; op < 8; op++) begin
            for (int i = 0; i < N; i++) set_req(i, 60, i + 1);
            do_op(op % N, 3, q_exp[op % N], 0, 1, 60, (op % N) + 1);
        end

        // Withdrawing requests before the edge leaves the block idle.
        req_valid_in = '0;
        step();
        #1;
        check("withdraw_busy", busy_out, 0);
        check("withdraw_quotient", quotient_out, 15);

        // Divide by zero on requester 2: immediate error result.
        set_req(2, 77, 0);
        do_op(2, 1, 0, 1, 0, 0, 0);

        // Divider never answers: timeout after 64 WAIT cycles.
        stub_lat = 0;
        set_req(3, 500, 5);
        do_op(3, TO + 2, 0, 1, 1, 500, 5);

        // A late response in IDLE is ignored.
        step();
        late_v = 1'b1;
        late_q = 9'sd55;
        #1;
        check("late_no_result", result_valid_out, 0);
        check("late_busy", busy_out, 0);
        step();
        late_v = 1'b0;
        #1;
        check("late_quotient", quotient_out, 0);
        check("late_error", error_out, 1);
        check("late_no_result2", result_valid_out, 0);

        // Move rr_ptr to 2, hang an operation, reset it mid-WAIT.
        stub_lat = 2;
        set_req(1, 45, 9);
        do_op(1, 4, 5, 0, 1, 45, 9);
        stub_lat = 0;
        set_req(2, 30, 3);
        #1;
        check("hang_grant", req_ready_out, 4'b0100);
        step();
        req_valid_in = '0;
        repeat (5) step();
        #1;
        check("hang_busy", busy_out, 1);
        step();
        rst_in = 1'b1;
        step();
        rst_in = 1'b0;
        #1;
        check("abort_busy", busy_out, 0);
        check("abort_div_valid", div_valid_out, 0);
        check("abort_div_dividend", div_dividend_out, 0);
        check("abort_div_divisor", div_divisor_out, 0);
        check("abort_quotient", quotient_out, 0);
        check("abort_error", error_out, 0);
        check("abort_result_valid", result_valid_out, 0);
        pulses = '0;
        repeat (TO + 16) begin
            step();
            #1;
            pulses |= result_valid_out;
        end
        check("abort_no_pulse", pulses, 0);

        // rr_ptr is back at 0, so requester 0 wins over 1 and 3.
        stub_lat = 1;
        set_req(0, 90, 9);
        set_req(1, 45, 9);
        set_req(3, -90, 9);
        do_op(0, 3, 10, 0, 1, 90, 9);
        req_valid_in = '0;
        repeat (4) step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
